// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised video timing + test-pattern generator.
//   clk, rst_n            pixel clock, async active-low reset
//   en                    generator enable; low clears and holds the counters
//   mode[2:0]             pattern select, latched at the top-left pixel
//   solid_rgb[23:0]       {r,g,b} for the solid pattern
//   hs, vs, de            syncs (polarity by HS_POL/VS_POL) and active video
//   x, y                  active pixel coordinates, 0 during blanking
//   frame_start           strobe on pixel (0,0)
//   line_start            strobe on x=0 of every active line
//   rgb_r, rgb_g, rgb_b   pixel data, black outside active video
// Every output is one register stage behind the counters, so all are aligned.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CNT_W    = 12,
  parameter int CHK_LOG2 = 5,
  parameter int RAMP_LSB = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [23:0]      solid_rgb,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start,
  output logic             line_start,
  output logic [7:0]       rgb_r,
  output logic [7:0]       rgb_g,
  output logic [7:0]       rgb_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t ONE      = cnt_t'(1);
  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t HA_C     = cnt_t'(H_ACTIVE);
  localparam cnt_t VA_C     = cnt_t'(V_ACTIVE);
  localparam cnt_t H_HALF   = cnt_t'(H_ACTIVE / 2);
  localparam cnt_t V_HALF   = cnt_t'(V_ACTIVE / 2);
  // Inclusive sync windows: an exclusive end could wrap to 0 when the
  // total equals 2^CNT_W and the back porch is empty.
  localparam cnt_t HS_FIRST = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_LAST  = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam cnt_t VS_FIRST = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_LAST  = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam cnt_t BAR_LAST = cnt_t'(H_ACTIVE / 8 - 1);

  localparam logic [23:0] WHITE   = 24'hffffff;
  localparam logic [23:0] YELLOW  = 24'hffff00;
  localparam logic [23:0] CYAN    = 24'h00ffff;
  localparam logic [23:0] GREEN   = 24'h00ff00;
  localparam logic [23:0] MAGENTA = 24'hff00ff;
  localparam logic [23:0] RED     = 24'hff0000;
  localparam logic [23:0] BLUE    = 24'h0000ff;
  localparam logic [23:0] BLACK   = 24'h000000;

  cnt_t       h_cnt, v_cnt;
  cnt_t       bar_cnt;      // position inside the current colour bar
  logic [2:0] bar_idx;      // current bar, saturating at 7
  logic [2:0] mode_q;

  logic       at_origin, de_n, hs_n, vs_n, fs_n, ls_n;
  logic [2:0] mode_eff;
  logic [23:0] pix_n;

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
      mode_q  <= '0;
    end else if (!en) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + ONE;
      end else begin
        h_cnt <= h_cnt + ONE;
      end
      // Bar tracker follows h_cnt so no divide by BAR_W is needed.
      if (h_cnt == H_LAST) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (bar_cnt == BAR_LAST) begin
        bar_cnt <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_cnt <= bar_cnt + ONE;
      end
      if (at_origin) mode_q <= mode;
    end
  end

  // -------------------------------------------------------- next outputs
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  // The frame_start pixel already uses the mode being captured on this edge.
  assign mode_eff  = at_origin ? mode : mode_q;

  assign de_n = en && (h_cnt < HA_C) && (v_cnt < VA_C);
  assign hs_n = (en && h_cnt >= HS_FIRST && h_cnt <= HS_LAST) ? HS_POL : ~HS_POL;
  assign vs_n = (en && v_cnt >= VS_FIRST && v_cnt <= VS_LAST) ? VS_POL : ~VS_POL;
  assign fs_n = en && at_origin;
  assign ls_n = en && (h_cnt == '0) && (v_cnt < VA_C);

  always_comb begin
    pix_n = BLACK;
    if (de_n) begin
      case (mode_eff)
        3'd0: pix_n = (h_cnt < H_HALF) ? ((v_cnt < V_HALF) ? WHITE  : CYAN)
                                       : ((v_cnt < V_HALF) ? YELLOW : GREEN);
        3'd1: begin
          case (bar_idx)
            3'd0:    pix_n = WHITE;
            3'd1:    pix_n = YELLOW;
            3'd2:    pix_n = CYAN;
            3'd3:    pix_n = GREEN;
            3'd4:    pix_n = MAGENTA;
            3'd5:    pix_n = RED;
            3'd6:    pix_n = BLUE;
            default: pix_n = BLACK;
          endcase
        end
        3'd2:    pix_n = (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) ? BLACK : WHITE;
        3'd3:    pix_n = {3{h_cnt[RAMP_LSB+7:RAMP_LSB]}};
        3'd4:    pix_n = solid_rgb;
        default: pix_n = BLACK;
      endcase
    end
  end

  // ------------------------------------------------------ output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      rgb_r       <= '0;
      rgb_g       <= '0;
      rgb_b       <= '0;
    end else begin
      hs          <= hs_n;
      vs          <= vs_n;
      de          <= de_n;
      x           <= de_n ? h_cnt : '0;
      y           <= de_n ? v_cnt : '0;
      frame_start <= fs_n;
      line_start  <= ls_n;
      {rgb_r, rgb_g, rgb_b} <= pix_n;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a small 24x12 raster. Two
// instances share the stimulus: one with active-high syncs, one active-low.
// Expected values come from a position-based model: output index p maps to
// h = p % H_TOTAL, v = (p / H_TOTAL) % V_TOTAL.
module tb_vga_timing_gen;
  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 8,  VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int CHK = 1, RLSB = 0, BARW = HA / 8, CW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic [23:0]   solid_rgb = 24'h0;

  logic          hs_a, vs_a, de_a, fs_a, ls_a;
  logic [CW-1:0] x_a, y_a;
  logic [7:0]    r_a, g_a, b_a;
  logic          hs_b, vs_b, de_b, fs_b, ls_b;
  logic [CW-1:0] x_b, y_b;
  logic [7:0]    r_b, g_b, b_b;

  int          n_checks = 0;
  int          n_fail = 0;
  int          p = -1;          // raster index of the outputs currently visible
  int          fmode = 0;       // mode latched at the last frame start
  logic [23:0] last_solid = 24'h0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(CW), .CHK_LOG2(CHK), .RAMP_LSB(RLSB)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .hs(hs_a), .vs(vs_a), .de(de_a), .x(x_a), .y(y_a),
    .frame_start(fs_a), .line_start(ls_a), .rgb_r(r_a), .rgb_g(g_a), .rgb_b(b_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW), .CHK_LOG2(CHK), .RAMP_LSB(RLSB)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .hs(hs_b), .vs(vs_b), .de(de_b), .x(x_b), .y(y_b),
    .frame_start(fs_b), .line_start(ls_b), .rgb_r(r_b), .rgb_g(g_b), .rgb_b(b_b)
  );

  // Observation bundles: {hs, vs, de, x, y, frame_start, line_start}
  wire [28:0] obs_a = {hs_a, vs_a, de_a, x_a, y_a, fs_a, ls_a};
  wire [28:0] obs_b = {hs_b, vs_b, de_b, x_b, y_b, fs_b, ls_b};
  wire [23:0] rgb_a = {r_a, g_a, b_a};
  wire [23:0] rgb_b = {r_b, g_b, b_b};

  // ------------------------------------------------------------ reference
  function automatic logic [28:0] model_tim(int pp, bit hpol, bit vpol);
    int h, v;
    bit d;
    h = pp % HT;
    v = (pp / HT) % VT;
    d = (h < HA) && (v < VA);
    return {(h >= HA + HFP && h < HA + HFP + HSW) ? hpol : ~hpol,
            (v >= VA + VFP && v < VA + VFP + VSW) ? vpol : ~vpol,
            d, d ? 12'(h) : 12'h0, d ? 12'(v) : 12'h0,
            (h == 0 && v == 0), (h == 0 && v < VA)};
  endfunction

  function automatic logic [23:0] model_pix(int m, int xx, int yy, logic [23:0] s);
    int idx;
    logic [7:0] g;
    case (m)
      0: begin
        if (xx < HA / 2) return (yy < VA / 2) ? 24'hffffff : 24'h00ffff;
        else             return (yy < VA / 2) ? 24'hffff00 : 24'h00ff00;
      end
      1: begin
        idx = xx / BARW;
        if (idx > 7) idx = 7;
        case (idx)
          0: return 24'hffffff;
          1: return 24'hffff00;
          2: return 24'h00ffff;
          3: return 24'h00ff00;
          4: return 24'hff00ff;
          5: return 24'hff0000;
          6: return 24'h0000ff;
          default: return 24'h000000;
        endcase
      end
      2: return ((((xx >> CHK) ^ (yy >> CHK)) & 1) == 0) ? 24'hffffff : 24'h000000;
      3: begin
        g = 8'((xx >> RLSB) & 255);
        return {g, g, g};
      end
      4: return s;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] model_rgb(int pp);
    int h, v;
    h = pp % HT;
    v = (pp / HT) % VT;
    if (h < HA && v < VA) return model_pix(fmode, h, v, last_solid);
    return 24'h0;
  endfunction

  // One clock: records the inputs seen by the edge, then samples #1 later.
  task automatic tick();
    logic [2:0] m;
    m = mode;
    last_solid = solid_rgb;
    @(posedge clk);
    #1;
    p++;
    if (p % FRAME == 0) fmode = int'(m);
  endtask

  task automatic align_frame();
    for (int i = 0; i < FRAME && ((p + 1) % FRAME) != 0; i++) tick();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 3'd0; solid_rgb = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs_a !== 29'h0 || rgb_a !== 24'h0) begin
      n_fail++; $display("FAIL reset_a: got %h/%h want %h/%h", obs_a, rgb_a, 29'h0, 24'h0);
    end
    n_checks++;
    if (obs_b !== {2'b11, 27'h0} || rgb_b !== 24'h0) begin
      n_fail++; $display("FAIL reset_b: got %h/%h want %h/%h", obs_b, rgb_b, {2'b11, 27'h0}, 24'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({de_a, x_a, y_a, fs_a, ls_a} !== {1'b1, 12'h0, 12'h0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL first_pixel: got de%b x%0d y%0d fs%b ls%b want de1 x0 y0 fs1 ls1",
                         de_a, x_a, y_a, fs_a, ls_a);
    end
  endtask

  task automatic test_line_timing();
    int de_cnt = 0, fs1 = -1, fs2 = -1, de_rise = -1, hs_rise = -1, hs_len = 0;
    int vs_rise = -1, vs_last = -1, vs_cnt = 0;
    logic pde = 1'b0, phs = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (obs_a !== model_tim(p, 1'b1, 1'b1) || rgb_a !== model_rgb(p)) begin
        n_fail++; $display("FAIL timing p=%0d: got %h/%h want %h/%h", p, obs_a, rgb_a,
                           model_tim(p, 1'b1, 1'b1), model_rgb(p));
      end
      if (fs_a) begin if (fs1 < 0) fs1 = k; else if (fs2 < 0) fs2 = k; end
      if (k < FRAME) begin
        if (de_a) de_cnt++;
        if (de_a && !pde && de_rise < 0) de_rise = k;
        if (hs_a && !phs && hs_rise < 0) hs_rise = k;
        if (hs_a && hs_rise >= 0 && k - hs_rise == hs_len) hs_len++;
        if (vs_a) begin if (vs_rise < 0) vs_rise = k; vs_last = k; vs_cnt++; end
      end
      pde = de_a; phs = hs_a;
    end
    n_checks++;
    if (de_cnt !== HA * VA) begin
      n_fail++; $display("FAIL de_per_frame: got %0d want %0d", de_cnt, HA * VA);
    end
    n_checks++;
    if (fs2 - fs1 !== FRAME) begin
      n_fail++; $display("FAIL frame_period: got %0d want %0d", fs2 - fs1, FRAME);
    end
    n_checks++;
    if (hs_rise - de_rise !== 18 || hs_len !== 3) begin
      n_fail++; $display("FAIL hs_window: got off %0d len %0d want off 18 len 3",
                         hs_rise - de_rise, hs_len);
    end
    n_checks++;
    if (vs_rise - fs1 !== 216 || vs_cnt !== 48 || vs_last - vs_rise + 1 !== 48) begin
      n_fail++; $display("FAIL vs_window: got off %0d cnt %0d span %0d want 216/48/48",
                         vs_rise - fs1, vs_cnt, vs_last - vs_rise + 1);
    end
  endtask

  task automatic test_bars();
    logic [23:0] want;
    bit pick;
    align_frame();
    mode = 3'd1;
    for (int k = 0; k < FRAME; k++) begin
      tick();
      n_checks++;
      if (rgb_a !== model_rgb(p)) begin
        n_fail++; $display("FAIL bars p=%0d: got %h want %h", p, rgb_a, model_rgb(p));
      end
      pick = 1'b1;
      case (p % HT)
        0, 1:       want = 24'hffffff;
        2:          want = 24'hffff00;
        8:          want = 24'hff00ff;
        14, 15, 20: want = 24'h000000;
        default:    begin want = 24'h0; pick = 1'b0; end
      endcase
      if (pick && (p % FRAME) / HT == 0) begin
        n_checks++;
        if (rgb_a !== want) begin
          n_fail++; $display("FAIL bar_x%0d: got %h want %h", p % HT, rgb_a, want);
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    int h, v, f;
    align_frame();
    mode = 3'd0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick();
      h = p % HT; v = (p / HT) % VT; f = k / FRAME;
      if (f == 0 && h == 0 && v == 3) begin mode = 3'd4; solid_rgb = 24'h123456; end
      n_checks++;
      if (rgb_a !== model_rgb(p)) begin
        n_fail++; $display("FAIL switch p=%0d: got %h want %h", p, rgb_a, model_rgb(p));
      end
      if (f == 0 && h == 12 && v == 6) begin
        n_checks++;
        if (rgb_a !== 24'h00ff00) begin
          n_fail++; $display("FAIL switch_quad: got %h want %h", rgb_a, 24'h00ff00);
        end
      end
      if (f == 1 && de_a) begin
        n_checks++;
        if (rgb_a !== 24'h123456) begin
          n_fail++; $display("FAIL switch_solid p=%0d: got %h want %h", p, rgb_a, 24'h123456);
        end
      end
    end
  endtask

  task automatic test_polarity_checker();
    int h, v;
    align_frame();
    mode = 3'd2;
    for (int k = 0; k < FRAME; k++) begin
      tick();
      h = p % HT; v = (p / HT) % VT;
      n_checks++;
      if (obs_b !== model_tim(p, 1'b0, 1'b0) || rgb_b !== model_rgb(p)) begin
        n_fail++; $display("FAIL pol_b p=%0d: got %h/%h want %h/%h", p, obs_b, rgb_b,
                           model_tim(p, 1'b0, 1'b0), model_rgb(p));
      end
      if ((h == 0 || h == 2) && (v == 0 || v == 2)) begin
        n_checks++;
        if (rgb_a !== ((h == v) ? 24'hffffff : 24'h0) || rgb_b !== rgb_a) begin
          n_fail++; $display("FAIL checker(%0d,%0d): got %h/%h want %h", h, v, rgb_a, rgb_b,
                             (h == v) ? 24'hffffff : 24'h0);
        end
      end
    end
  endtask

  task automatic test_random_frames();
    logic [2:0] start_mode [4];
    start_mode[0] = 3'd4; start_mode[1] = 3'd3;
    start_mode[2] = 3'($urandom_range(0, 7)); start_mode[3] = 3'($urandom_range(0, 7));
    for (int f = 0; f < 4; f++) begin
      align_frame();
      mode = start_mode[f];
      for (int k = 0; k < FRAME; k++) begin
        tick();
        solid_rgb = 24'($urandom);
        if ($urandom_range(0, 49) == 0) mode = 3'($urandom_range(0, 7));
        n_checks++;
        if (obs_a !== model_tim(p, 1'b1, 1'b1) || rgb_a !== model_rgb(p)) begin
          n_fail++; $display("FAIL random m%0d p=%0d: got %h/%h want %h/%h", fmode, p, obs_a,
                             rgb_a, model_tim(p, 1'b1, 1'b1), model_rgb(p));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < FRAME && (p % FRAME) != 5 * HT + 7; i++) tick();
    n_checks++;
    if (x_a !== 12'd7 || y_a !== 12'd5) begin
      n_fail++; $display("FAIL pre_reset_pos: got x%0d y%0d want x7 y5", x_a, y_a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs_a !== 29'h0 || rgb_a !== 24'h0 || obs_b !== {2'b11, 27'h0}) begin
      n_fail++; $display("FAIL async_reset: got %h/%h/%h want %h/%h/%h", obs_a, rgb_a, obs_b,
                         29'h0, 24'h0, {2'b11, 27'h0});
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      n_checks++;
      if (obs_a !== 29'h0 || rgb_a !== 24'h0 || obs_b !== {2'b11, 27'h0}) begin
        n_fail++; $display("FAIL idle k=%0d: got %h/%h/%h want %h/%h/%h", k, obs_a, rgb_a,
                           obs_b, 29'h0, 24'h0, {2'b11, 27'h0});
      end
    end
    mode = 3'd3;
    en = 1'b1;
    p = -1;
    tick();
    n_checks++;
    if ({de_a, x_a, y_a, fs_a, ls_a} !== {1'b1, 12'h0, 12'h0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL restart: got de%b x%0d y%0d fs%b ls%b want de1 x0 y0 fs1 ls1",
                         de_a, x_a, y_a, fs_a, ls_a);
    end
    tick();
    n_checks++;
    if (rgb_a !== 24'h010101) begin
      n_fail++; $display("FAIL restart_ramp: got %h want %h", rgb_a, 24'h010101);
    end
    for (int k = 0; k < 2 * HT; k++) begin
      tick();
      n_checks++;
      if (obs_a !== model_tim(p, 1'b1, 1'b1) || rgb_a !== model_rgb(p)) begin
        n_fail++; $display("FAIL restart_run p=%0d: got %h/%h want %h/%h", p, obs_a, rgb_a,
                           model_tim(p, 1'b1, 1'b1), model_rgb(p));
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_bars();
    test_mode_switch();
    test_polarity_checker();
    test_random_frames();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
